// File: rtl/tdm_deframer.sv
// tdm_deframer: rebuilds NO_CHANNEL parallel channel words from a TDM word
// stream. Frames start with an SOF-tagged word on channel 0. A partial frame
// is collected in a shadow array and copied to the registered output only
// when the last channel word arrives.
module tdm_deframer #(
    parameter int DATA_WIDTH = 8,
    parameter int MSEL_WIDTH = 1,
    parameter int NO_CHANNEL = 2 ** MSEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [MSEL_WIDTH-1:0] sel,
    output logic [DATA_WIDTH-1:0] out [NO_CHANNEL],
    output logic                  out_valid,
    output logic                  frame_err,
    output logic                  drop
);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    localparam logic [MSEL_WIDTH-1:0] LAST_CH  = MSEL_WIDTH'(NO_CHANNEL - 1);
    localparam logic [MSEL_WIDTH-1:0] FIRST_CH = MSEL_WIDTH'(1);

    state_t                  state_q;
    logic [MSEL_WIDTH-1:0]   cnt_q;
    logic [MSEL_WIDTH-1:0]   cnt_d;
    logic [DATA_WIDTH-1:0]   shd_q [NO_CHANNEL];
    logic [DATA_WIDTH-1:0]   out_q [NO_CHANNEL];
    logic                    outValid_q;
    logic                    frameErr_q;
    logic                    drop_q;

    // Channel index that follows the one being written this cycle.
    always_comb begin
        cnt_d = cnt_q + FIRST_CH;
    end

    // Hunt/collect state machine; shadow array is left unreset on purpose.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            outValid_q <= 1'b0;
            frameErr_q <= 1'b0;
            drop_q     <= 1'b0;
            for (int i = 0; i < NO_CHANNEL; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            outValid_q <= 1'b0;
            frameErr_q <= 1'b0;
            drop_q     <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            shd_q[0] <= in;
                            cnt_q    <= FIRST_CH;
                            state_q  <= COLLECT;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            frameErr_q <= 1'b1;
                            shd_q[0]   <= in;
                            cnt_q      <= FIRST_CH;
                        end else begin
                            shd_q[cnt_q] <= in;
                            if (cnt_q == LAST_CH) begin
                                for (int i = 0; i < NO_CHANNEL - 1; i++) begin
                                    out_q[i] <= shd_q[i];
                                end
                                out_q[NO_CHANNEL-1] <= in;
                                outValid_q          <= 1'b1;
                                cnt_q               <= '0;
                                state_q             <= HUNT;
                            end else begin
                                cnt_q <= cnt_d;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= HUNT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // cnt is held at zero whenever the machine is hunting, so it doubles as sel.
    always_comb begin
        sel       = cnt_q;
        out       = out_q;
        out_valid = outValid_q;
        frame_err = frameErr_q;
        drop      = drop_q;
    end

endmodule

// File: tb/tb_tdm_deframer.sv
// tb_tdm_deframer: directed checks of the TDM deframer with four channels.
module tb_tdm_deframer;

    logic       clock;
    logic       reset;
    logic       inValid;
    logic       inSof;
    logic [7:0] inData;
    logic [1:0] sel;
    logic [7:0] outWords [4];
    logic       outValid;
    logic       frameErr;
    logic       dropStrobe;

    int vecCount  = 0;
    int missCount = 0;

    tdm_deframer #(
        .DATA_WIDTH(8),
        .MSEL_WIDTH(2),
        .NO_CHANNEL(4)
    ) dut (
        .clk      (clock),
        .rst      (reset),
        .in_valid (inValid),
        .in_sof   (inSof),
        .in       (inData),
        .sel      (sel),
        .out      (outWords),
        .out_valid(outValid),
        .frame_err(frameErr),
        .drop     (dropStrobe)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one word, advance one edge, and settle before sampling.
    task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
        inValid = v;
        inSof   = s;
        inData  = d;
        @(posedge clock);
        #1;
    endtask

    // One comparison against a hand-computed value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp)
        else begin
            missCount++;
            $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Strobes and channel index after an edge.
    task automatic checkStrobes(input string tag, input logic [1:0] expSel,
                                input logic expOv, input logic expErr, input logic expDrop);
        checkOutput({tag, ".sel"}, 32'(sel), 32'(expSel));
        checkOutput({tag, ".out_valid"}, 32'(outValid), 32'(expOv));
        checkOutput({tag, ".frame_err"}, 32'(frameErr), 32'(expErr));
        checkOutput({tag, ".drop"}, 32'(dropStrobe), 32'(expDrop));
    endtask

    // Full output frame.
    task automatic checkFrame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        checkOutput({tag, ".out0"}, 32'(outWords[0]), 32'(e0));
        checkOutput({tag, ".out1"}, 32'(outWords[1]), 32'(e1));
        checkOutput({tag, ".out2"}, 32'(outWords[2]), 32'(e2));
        checkOutput({tag, ".out3"}, 32'(outWords[3]), 32'(e3));
    endtask

    // Directed sequence of all scenarios.
    initial begin
        reset   = 1'b1;
        inValid = 1'b0;
        inSof   = 1'b0;
        inData  = 8'h00;
        @(posedge clock);
        @(posedge clock);
        #1;
        checkStrobes("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        checkFrame("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;

        // Nominal frame.
        applyStimulus(1'b1, 1'b1, 8'h11);
        checkStrobes("nom.w0", 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h22);
        checkStrobes("nom.w1", 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h33);
        checkStrobes("nom.w2", 2'd3, 1'b0, 1'b0, 1'b0);
        checkFrame("nom.w2", 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h44);
        checkStrobes("nom.w3", 2'd0, 1'b1, 1'b0, 1'b0);
        checkFrame("nom.w3", 8'h11, 8'h22, 8'h33, 8'h44);
        applyStimulus(1'b0, 1'b0, 8'hEE);
        checkStrobes("nom.idle", 2'd0, 1'b0, 1'b0, 1'b0);
        checkFrame("nom.idle", 8'h11, 8'h22, 8'h33, 8'h44);

        // Back-to-back frames with gaps.
        applyStimulus(1'b1, 1'b1, 8'hA0);
        checkStrobes("b2b.a0", 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        checkStrobes("b2b.gap1", 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hA1);
        applyStimulus(1'b0, 1'b0, 8'hFE);
        applyStimulus(1'b0, 1'b0, 8'hFD);
        checkStrobes("b2b.gap2", 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hA2);
        applyStimulus(1'b1, 1'b0, 8'hA3);
        checkStrobes("b2b.a3", 2'd0, 1'b1, 1'b0, 1'b0);
        checkFrame("b2b.a3", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        applyStimulus(1'b1, 1'b1, 8'hB0);
        checkStrobes("b2b.b0", 2'd1, 1'b0, 1'b0, 1'b0);
        checkFrame("b2b.b0", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        applyStimulus(1'b1, 1'b0, 8'hB1);
        applyStimulus(1'b0, 1'b0, 8'hFC);
        checkStrobes("b2b.gap3", 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hB2);
        checkFrame("b2b.b2", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        applyStimulus(1'b1, 1'b0, 8'hB3);
        checkStrobes("b2b.b3", 2'd0, 1'b1, 1'b0, 1'b0);
        checkFrame("b2b.b3", 8'hB0, 8'hB1, 8'hB2, 8'hB3);

        // Early SOF aborts the partial frame.
        applyStimulus(1'b1, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h02);
        checkStrobes("esof.w1", 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h10);
        checkStrobes("esof.sof2", 2'd1, 1'b0, 1'b1, 1'b0);
        checkFrame("esof.sof2", 8'hB0, 8'hB1, 8'hB2, 8'hB3);
        applyStimulus(1'b1, 1'b0, 8'h20);
        checkStrobes("esof.w20", 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h30);
        applyStimulus(1'b1, 1'b0, 8'h40);
        checkStrobes("esof.done", 2'd0, 1'b1, 1'b0, 1'b0);
        checkFrame("esof.done", 8'h10, 8'h20, 8'h30, 8'h40);

        // Early SOF on the last position.
        applyStimulus(1'b1, 1'b1, 8'h61);
        applyStimulus(1'b1, 1'b0, 8'h62);
        applyStimulus(1'b1, 1'b0, 8'h63);
        applyStimulus(1'b1, 1'b1, 8'h64);
        checkStrobes("lsof", 2'd1, 1'b0, 1'b1, 1'b0);
        checkFrame("lsof", 8'h10, 8'h20, 8'h30, 8'h40);

        // Hunting from reset.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        checkFrame("hunt.rst", 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h55);
        checkStrobes("hunt.55", 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h66);
        checkStrobes("hunt.66", 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h71);
        checkStrobes("hunt.sof", 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h72);
        applyStimulus(1'b1, 1'b0, 8'h73);
        applyStimulus(1'b1, 1'b0, 8'h74);
        checkStrobes("hunt.done", 2'd0, 1'b1, 1'b0, 1'b0);
        checkFrame("hunt.done", 8'h71, 8'h72, 8'h73, 8'h74);

        // Reset mid-frame.
        applyStimulus(1'b1, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h02);
        applyStimulus(1'b1, 1'b0, 8'h03);
        applyStimulus(1'b1, 1'b0, 8'h04);
        checkFrame("mrst.pre", 8'h01, 8'h02, 8'h03, 8'h04);
        applyStimulus(1'b1, 1'b1, 8'h09);
        applyStimulus(1'b1, 1'b0, 8'h08);
        checkStrobes("mrst.part", 2'd2, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h07);
        reset = 1'b0;
        checkStrobes("mrst.rst", 2'd0, 1'b0, 1'b0, 1'b0);
        checkFrame("mrst.rst", 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h05);
        checkStrobes("mrst.hunt", 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h0A);
        applyStimulus(1'b1, 1'b0, 8'h0B);
        applyStimulus(1'b1, 1'b0, 8'h0C);
        applyStimulus(1'b1, 1'b0, 8'h0D);
        checkStrobes("mrst.done", 2'd0, 1'b1, 1'b0, 1'b0);
        checkFrame("mrst.done", 8'h0A, 8'h0B, 8'h0C, 8'h0D);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkStrobes("mrst.idle", 2'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/tdm_deframer.md
# tdm_deframer

Receive-side companion to the channel multiplexer: takes a time-division-multiplexed word stream, one channel per accepted word, and rebuilds the NO_CHANNEL parallel channel words. Frames are delimited by a start-of-frame marker on channel 0. A completed frame is presented as a registered array with a one-cycle strobe. It sits at the far end of a serial data link, feeding per-channel consumers or a `data_demux` feedback path.

## Interface
- DATA_WIDTH, 8, width of each channel word
- MSEL_WIDTH, 1, channel index width; must be >= 1
- NO_CHANNEL, 2**MSEL_WIDTH, channels per frame; legal range 2..2**MSEL_WIDTH

- clk  input  1  single clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  word on `in` is accepted this cycle
- in_sof  input  1  accepted word is channel 0 of a new frame; ignored when in_valid=0
- in  input  DATA_WIDTH  TDM data word
- sel  output  MSEL_WIDTH  channel index the next accepted word will be written to; 0 while hunting
- out  output  DATA_WIDTH x [NO_CHANNEL]  last complete frame, unpacked array, index = channel
- out_valid  output  1  one-cycle strobe: `out` was updated this cycle
- frame_err  output  1  one-cycle strobe: frame aborted by early SOF
- drop  output  1  one-cycle strobe: non-SOF word discarded while hunting

## Operation
- Two states: HUNT and COLLECT. Channel counter `cnt` has MSEL_WIDTH bits. Shadow array `shd[NO_CHANNEL]` holds the partial frame.
- HUNT:
  - in_valid & in_sof: shd[0]<=in, cnt<=1, go to COLLECT.
  - in_valid & !in_sof: word discarded, drop pulses.
  - Otherwise hold.
- COLLECT, in_valid & !in_sof:
  - shd[cnt]<=in.
  - If cnt==NO_CHANNEL-1: out[i]<=shd[i] for i<cnt, out[cnt]<=in, out_valid pulses, cnt<=0, go to HUNT.
  - Else cnt<=cnt+1.
- COLLECT, in_valid & in_sof (early SOF, including on the last position):
  - Partial frame discarded; `out` unchanged.
  - frame_err pulses.
  - shd[0]<=in, cnt<=1, stay in COLLECT. The new frame starts with this word.
- COLLECT, in_valid=0: pause, all state held. There is no timeout.
- sel = cnt in COLLECT, 0 in HUNT.
- `out` changes only on frame completion. Between completions it holds the previous frame.
- `shd` contents are never visible on `out` until the frame completes.
- A word carrying in_sof immediately after a completed frame is normal frame start: no drop, no error.

## Timing
- Reset values: state HUNT, cnt 0, sel 0, out all zeros, out_valid 0, frame_err 0, drop 0. `shd` need not be reset.
- rst asserted mid-frame: the partial frame is lost, `out` is cleared to zero, and no strobe fires. An in_valid word in the cycle rst is high is ignored.
- Latency: `out` and out_valid update on the clock edge that accepts the last channel word. They are visible the cycle after that word is presented.
- All strobes (out_valid, frame_err, drop) are registered and high for exactly one cycle per event, with no combinational path from inputs.
- frame_err and out_valid are never high in the same cycle.
- sel is registered and reflects the state after the current edge.
- Sustained throughput: one word per cycle, back-to-back frames with no idle cycle required. SOF may follow the last word of the previous frame directly.

## Test plan
- Use DATA_WIDTH=8, MSEL_WIDTH=2, NO_CHANNEL=4 throughout.
- Nominal frame: SOF+0x11, then 0x22, 0x33, 0x44 on consecutive cycles. Required: out={0x11,0x22,0x33,0x44} and out_valid=1 on the cycle after 0x44, then 0 on the next cycle; sel sequence 1,2,3,0.
- Back-to-back frames with random in_valid gaps: frames {0xA0..0xA3} then {0xB0..0xB3}. Required: two out_valid pulses, out holds {0xA0..0xA3} until the second completion, and gaps do not advance sel.
- Early SOF: SOF+0x01, 0x02, SOF+0x10, 0x20, 0x30, 0x40. Required: frame_err pulse after the second SOF, then out={0x10,0x20,0x30,0x40} with a single out_valid, and out never shows 0x01/0x02.
- Hunting: from reset, send 0x55, 0x66 without SOF, then a full frame. Required: two drop pulses, sel stays 0, then normal completion.
- Reset mid-frame: complete frame {1,2,3,4}, then SOF+9, 8, then rst for 1 cycle. Required: out=all 0, state HUNT, no strobes; the next full frame completes normally.
